sdram_port_arbiter: RTL and testbench

- Shares the single 8-bit SDRAM client port between three requesters: the game loader (write-only), the NES CPU (read/write) and the NES PPU (read-only).
- Issues at most one command per SDRAM slot; slots are marked by a one-cycle slot_start strobe derived from the NES clock-enable phase.
- Routes read data back to the owner with a fixed latency.
- Sits between flash loader / NES core and the sdram controller, replacing the ad-hoc load_done muxing at top level.

---
 rtl/sdram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: slot-based arbiter sharing one 8-bit SDRAM port between loader, CPU and PPU.
// Optional ARB_STATS_EN adds saturating grant/conflict counters.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int SLOT_LEN   = 4,
  parameter int RD_LATENCY = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              slot_start,
  input  logic              loader_mode,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_rdata,
  output logic              ppu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [7:0]        mem_din,
`ifdef ARB_STATS_EN
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_ppu,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_conflict,
`endif
  input  logic [7:0]        mem_dout
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
  typedef enum logic [1:0] {T_NONE, T_CPU, T_PPU} tag_t;

  if (RD_LATENCY < 1 || RD_LATENCY >= SLOT_LEN) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..SLOT_LEN-1");
  end

  state_t state, state_nxt;
  tag_t   tag_q [RD_LATENCY];
  tag_t   tag_in;
  logic   last_ppu;
  logic   gnt_ld, gnt_cpu, gnt_ppu;

  // last_ppu=1 means PPU won the previous contested/uncontested CPU-PPU slot
  always_comb begin
    gnt_ld    = slot_start && loader_mode && ld_req;
    gnt_cpu   = slot_start && !loader_mode && cpu_req && (!ppu_req || last_ppu);
    gnt_ppu   = slot_start && !loader_mode && ppu_req && (!cpu_req || !last_ppu);
    state_nxt = !slot_start ? state :
                gnt_ld      ? S_WRITE :
                gnt_cpu     ? (cpu_we ? S_WRITE : S_READ) :
                gnt_ppu     ? S_READ : S_IDLE;
    tag_in    = (gnt_cpu && !cpu_we) ? T_CPU : gnt_ppu ? T_PPU : T_NONE;
  end

  assign mem_we = (state == S_WRITE);
  assign mem_oe = (state == S_READ);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      last_ppu   <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      ld_ack     <= 1'b0;
      cpu_ack    <= 1'b0;
      ppu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ppu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      ppu_rvalid <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= T_NONE;
    end else begin
      state   <= state_nxt;
      ld_ack  <= gnt_ld;
      cpu_ack <= gnt_cpu;
      ppu_ack <= gnt_ppu;
      if (gnt_cpu || gnt_ppu) last_ppu <= gnt_ppu;
      if (gnt_ld) begin
        mem_addr <= ld_addr;
        mem_din  <= ld_wdata;
      end else if (gnt_cpu) begin
        mem_addr <= cpu_addr;
        if (cpu_we) mem_din <= cpu_wdata;
      end else if (gnt_ppu) begin
        mem_addr <= ppu_addr;
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      cpu_rvalid <= (tag_q[RD_LATENCY-1] == T_CPU);
      ppu_rvalid <= (tag_q[RD_LATENCY-1] == T_PPU);
      if (tag_q[RD_LATENCY-1] == T_CPU) cpu_rdata <= mem_dout;
      if (tag_q[RD_LATENCY-1] == T_PPU) ppu_rdata <= mem_dout;
    end
  end

`ifdef ARB_STATS_EN
  logic both;
  assign both = slot_start && !loader_mode && cpu_req && ppu_req;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_cpu      <= '0;
      stat_ppu      <= '0;
      stat_ld       <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt_cpu && stat_cpu != 16'hFFFF) stat_cpu <= stat_cpu + 16'd1;
      if (gnt_ppu && stat_ppu != 16'hFFFF) stat_ppu <= stat_ppu + 16'd1;
      if (gnt_ld && stat_ld != 16'hFFFF) stat_ld <= stat_ld + 16'd1;
      if (both && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenario tests for sdram_port_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sdram_port_arbiter;
  localparam int AW = 22;

  logic          clock = 1'b0, resetn = 1'b0, slot_start = 1'b0, loader_mode = 1'b0;
  logic          ld_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, ppu_req = 1'b0;
  logic [AW-1:0] ld_addr = '0, cpu_addr = '0, ppu_addr = '0;
  logic [7:0]    ld_wdata = '0, cpu_wdata = '0, mem_dout = '0;
  logic          ld_ack, cpu_ack, ppu_ack, cpu_rvalid, ppu_rvalid, mem_we, mem_oe;
  logic [7:0]    cpu_rdata, ppu_rdata, mem_din;
  logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_cpu, stat_ppu, stat_ld, stat_conflict;
`endif
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  sdram_port_arbiter dut (
    .clock(clock), .resetn(resetn), .slot_start(slot_start), .loader_mode(loader_mode),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack),
    .ppu_rdata(ppu_rdata), .ppu_rvalid(ppu_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_din(mem_din),
`ifdef ARB_STATS_EN
    .stat_cpu(stat_cpu), .stat_ppu(stat_ppu), .stat_ld(stat_ld), .stat_conflict(stat_conflict),
`endif
    .mem_dout(mem_dout)
  );

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_slot();
    ld_req = 0; cpu_req = 0; ppu_req = 0; slot_start = 1;
    step();
    slot_start = 0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    step();
    total++;
    if ({ld_ack, cpu_ack, ppu_ack, cpu_rvalid, ppu_rvalid, mem_we, mem_oe, mem_addr, mem_din, cpu_rdata, ppu_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs got nonzero ack=%b%b%b we=%b oe=%b addr=%h", ld_ack, cpu_ack, ppu_ack, mem_we, mem_oe, mem_addr);
    end
    resetn = 1;
    step();
  endtask

  task automatic test_loader();
    int rv = 0;
    loader_mode = 1; ld_req = 1; ld_addr = 22'h000010; ld_wdata = 8'hA5; slot_start = 1;
    step();
    slot_start = 0; ld_req = 0;
    total++;
    if (ld_ack !== 1'b1) begin bad++; $display("FAIL ld_ack got=%b exp=1", ld_ack); end
    total++;
    if ({mem_we, mem_oe, mem_addr, mem_din} !== {1'b1, 1'b0, 22'h000010, 8'hA5}) begin
      bad++; $display("FAIL ld_cmd got we=%b oe=%b addr=%h din=%h exp we=1 oe=0 addr=000010 din=a5", mem_we, mem_oe, mem_addr, mem_din);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      rv += int'(cpu_rvalid) + int'(ppu_rvalid);
      total++;
      if ({ld_ack, mem_we, mem_addr, mem_din} !== {1'b0, 1'b1, 22'h000010, 8'hA5}) begin
        bad++; $display("FAIL ld_hold cyc%0d got ack=%b we=%b addr=%h din=%h", c, ld_ack, mem_we, mem_addr, mem_din);
      end
    end
    idle_slot();
    total++;
    if ({mem_we, mem_addr} !== {1'b0, 22'h000010}) begin
      bad++; $display("FAIL ld_idle got we=%b addr=%h exp we=0 addr=000010", mem_we, mem_addr);
    end
    total++;
    if (rv !== 0) begin bad++; $display("FAIL ld_no_rvalid got=%0d exp=0", rv); end
  endtask

  task automatic test_cpu_read();
    loader_mode = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 22'h008000; slot_start = 1;
    step();
    slot_start = 0; cpu_req = 0;
    total++;
    if ({cpu_ack, ppu_ack, mem_oe, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 22'h008000}) begin
      bad++; $display("FAIL cpu_rd_issue got ack=%b%b oe=%b we=%b addr=%h exp 10 1 0 008000", cpu_ack, ppu_ack, mem_oe, mem_we, mem_addr);
    end
    step();
    total++;
    if ({cpu_ack, cpu_rvalid} !== 2'b00) begin bad++; $display("FAIL cpu_rd_t2 got ack=%b rvalid=%b exp 0 0", cpu_ack, cpu_rvalid); end
    step();
    mem_dout = 8'h4C;
    total++;
    if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL cpu_rd_t3 rvalid got=%b exp=0", cpu_rvalid); end
    step();
    mem_dout = 8'h00;
    total++;
    if ({cpu_rvalid, cpu_rdata, ppu_rvalid} !== {1'b1, 8'h4C, 1'b0}) begin
      bad++; $display("FAIL cpu_rd_ret got rvalid=%b rdata=%h ppu_rvalid=%b exp 1 4c 0", cpu_rvalid, cpu_rdata, ppu_rvalid);
    end
    step();
    total++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h4C}) begin
      bad++; $display("FAIL cpu_rd_hold got rvalid=%b rdata=%h exp 0 4c", cpu_rvalid, cpu_rdata);
    end
    idle_slot();
  endtask

  task automatic test_round_robin();
    int acks;
    logic exp_ppu;
    loader_mode = 0; cpu_req = 1; ppu_req = 1; cpu_we = 0; cpu_addr = 22'h000100; ppu_addr = 22'h000200;
    for (int s = 0; s < 4; s++) begin
      exp_ppu = (s % 2 == 0);
      slot_start = 1;
      step();
      slot_start = 0;
      total++;
      if ({cpu_ack, ppu_ack, mem_addr} !== {!exp_ppu, exp_ppu, exp_ppu ? 22'h000200 : 22'h000100}) begin
        bad++; $display("FAIL rr_slot%0d got ack=%b%b addr=%h exp ppu=%b", s, cpu_ack, ppu_ack, mem_addr, exp_ppu);
      end
      acks = int'(cpu_ack) + int'(ppu_ack);
      repeat (3) begin
        step();
        acks += int'(cpu_ack) + int'(ppu_ack);
      end
      total++;
      if (acks !== 1) begin bad++; $display("FAIL rr_acks_slot%0d got=%0d exp=1", s, acks); end
    end
`ifdef ARB_STATS_EN
    total++;
    if (stat_conflict !== 16'd4) begin bad++; $display("FAIL stat_conflict got=%0d exp=4", stat_conflict); end
`endif
    idle_slot();
  endtask

  task automatic test_cpu_write();
    int rv = 0;
    loader_mode = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 22'h001234; cpu_wdata = 8'h5A; slot_start = 1;
    step();
    slot_start = 0; cpu_req = 0;
    total++;
    if ({cpu_ack, mem_we, mem_oe, mem_addr, mem_din} !== {1'b1, 1'b1, 1'b0, 22'h001234, 8'h5A}) begin
      bad++; $display("FAIL cpu_wr got ack=%b we=%b oe=%b addr=%h din=%h exp 1 1 0 001234 5a", cpu_ack, mem_we, mem_oe, mem_addr, mem_din);
    end
    repeat (5) begin
      step();
      rv += int'(cpu_rvalid) + int'(ppu_rvalid);
    end
    total++;
    if (rv !== 0) begin bad++; $display("FAIL cpu_wr_no_rvalid got=%0d exp=0", rv); end
    cpu_we = 0;
    idle_slot();
  endtask

  task automatic test_short_slot();
    loader_mode = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 22'h0000AA; slot_start = 1;
    step();
    slot_start = 0; cpu_req = 0;
    total++;
    if (cpu_ack !== 1'b1) begin bad++; $display("FAIL short_cpu_ack got=%b exp=1", cpu_ack); end
    step();
    ppu_req = 1; ppu_addr = 22'h0000BB; slot_start = 1;
    step();
    slot_start = 0; ppu_req = 0; mem_dout = 8'h11;
    total++;
    if ({ppu_ack, mem_oe, mem_addr} !== {1'b1, 1'b1, 22'h0000BB}) begin
      bad++; $display("FAIL short_ppu_issue got ack=%b oe=%b addr=%h exp 1 1 0000bb", ppu_ack, mem_oe, mem_addr);
    end
    step();
    mem_dout = 8'h00;
    total++;
    if ({cpu_rvalid, cpu_rdata, ppu_rvalid} !== {1'b1, 8'h11, 1'b0}) begin
      bad++; $display("FAIL short_cpu_ret got rvalid=%b rdata=%h ppu_rvalid=%b exp 1 11 0", cpu_rvalid, cpu_rdata, ppu_rvalid);
    end
    step();
    mem_dout = 8'h22;
    step();
    mem_dout = 8'h00;
    total++;
    if ({ppu_rvalid, ppu_rdata, cpu_rvalid} !== {1'b1, 8'h22, 1'b0}) begin
      bad++; $display("FAIL short_ppu_ret got rvalid=%b rdata=%h cpu_rvalid=%b exp 1 22 0", ppu_rvalid, ppu_rdata, cpu_rvalid);
    end
    idle_slot();
  endtask

  task automatic test_loader_mode_ignores();
    int evt = 0;
    loader_mode = 1; cpu_req = 1; ppu_req = 1; cpu_we = 0; ld_req = 0; slot_start = 1;
    for (int c = 0; c < 8; c++) begin
      step();
      slot_start = (c % 4 == 3);
      evt += int'(cpu_ack) + int'(ppu_ack) + int'(ld_ack) + int'(mem_oe) + int'(mem_we);
    end
    total++;
    if (evt !== 0) begin bad++; $display("FAIL ldmode_ignore got events=%0d exp=0", evt); end
    ld_req = 1; ld_addr = 22'h000033; ld_wdata = 8'hC3;
    step();
    slot_start = 0; ld_req = 0; cpu_req = 0; ppu_req = 0;
    total++;
    if ({ld_ack, cpu_ack, ppu_ack, mem_we, mem_oe, mem_addr, mem_din} !== {5'b10010, 22'h000033, 8'hC3}) begin
      bad++; $display("FAIL ldmode_grant got ack=%b%b%b we=%b oe=%b addr=%h din=%h exp 100 1 0 000033 c3", ld_ack, cpu_ack, ppu_ack, mem_we, mem_oe, mem_addr, mem_din);
    end
    repeat (3) step();
    idle_slot();
  endtask

  task automatic test_reset_inflight();
    int rv = 0;
    loader_mode = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000077; slot_start = 1;
    step();
    slot_start = 0; cpu_req = 0; mem_dout = 8'hFF;
    total++;
    if (cpu_ack !== 1'b1) begin bad++; $display("FAIL rst_pre_ack got=%b exp=1", cpu_ack); end
    #1 resetn = 0;
    #1;
    total++;
    if ({ld_ack, cpu_ack, ppu_ack, cpu_rvalid, ppu_rvalid, mem_we, mem_oe, mem_addr, mem_din, cpu_rdata, ppu_rdata} !== '0) begin
      bad++; $display("FAIL rst_async got ack=%b oe=%b addr=%h rdata=%h exp all 0", cpu_ack, mem_oe, mem_addr, cpu_rdata);
    end
    step();
    step();
    resetn = 1;
    repeat (6) begin
      step();
      rv += int'(cpu_rvalid) + int'(ppu_rvalid);
    end
    total++;
    if (rv !== 0) begin bad++; $display("FAIL rst_no_rvalid got=%0d exp=0", rv); end
    mem_dout = 8'h00; cpu_req = 1; slot_start = 1;
    step();
    slot_start = 0; cpu_req = 0;
    total++;
    if ({cpu_ack, mem_oe, mem_addr} !== {1'b1, 1'b1, 22'h000077}) begin
      bad++; $display("FAIL rst_regrant got ack=%b oe=%b addr=%h exp 1 1 000077", cpu_ack, mem_oe, mem_addr);
    end
    repeat (3) step();
    idle_slot();
  endtask

  task automatic test_dropped_request();
    int evt = 0;
    loader_mode = 1; slot_start = 1;
    step();
    slot_start = 0; ld_req = 1; ld_addr = 22'h000044; ld_wdata = 8'h99;
    evt += int'(ld_ack) + int'(mem_we);
    step();
    ld_req = 0;
    evt += int'(ld_ack) + int'(mem_we);
    step();
    evt += int'(ld_ack) + int'(mem_we);
    step();
    slot_start = 1;
    evt += int'(ld_ack) + int'(mem_we);
    step();
    slot_start = 0;
    evt += int'(ld_ack) + int'(mem_we);
    step();
    evt += int'(ld_ack) + int'(mem_we);
    total++;
    if (evt !== 0) begin bad++; $display("FAIL dropped_req got events=%0d exp=0", evt); end
    total++;
    if (mem_addr === 22'h000044) begin bad++; $display("FAIL dropped_addr got=%h exp not 000044", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_loader();
    test_cpu_read();
    test_round_robin();
    test_cpu_write();
    test_short_slot();
    test_loader_mode_ignores();
    test_reset_inflight();
    test_dropped_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
